// File: rtl/memory_system_lsq.sv
// In-order load/store queue in front of a fixed-latency word-addressed backing store.
// Requests complete oldest-first; load completions pulse ready_out with data and id.
module memory_system_lsq #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rw_in,
    input  logic                     valid_in,
    input  logic [ID_W-1:0]          id_in,
    output logic [DATA_W-1:0]        data_out,
    output logic [ID_W-1:0]          id_out,
    output logic                     ready_out,
    output logic                     stall_out,
    output logic [$clog2(DEPTH):0]   count_out
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // Only the word index is kept per entry; byte offset and upper bits alias away.
    logic [IDX_W-1:0]  q_idx_q  [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic              q_rw_q   [DEPTH];
    logic [ID_W-1:0]   q_id_q   [DEPTH];
    logic [DATA_W-1:0] mem_q    [MEM_WORDS];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [ID_W-1:0]   id_out_q, id_out_d;

    logic             push, pop, full;
    logic [IDX_W-1:0] in_idx, head_idx;
    logic             unused_addr;

    assign in_idx      = addr_in[IDX_W+1:2];
    assign unused_addr = ^{addr_in[ADDR_W-1:IDX_W+2], addr_in[1:0]};
    assign head_idx    = q_idx_q[head_q];

    assign full = (count_q == CNT_FULL);
    assign push = valid_in && !full;
    assign pop  = (state_q == ST_BUSY) && (wait_cnt_q == '0);

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ready_d    = 1'b0;
        data_out_d = data_out_q;
        id_out_d   = id_out_q;

        if (push) tail_d = tail_q + PTR_W'(1);
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        if (state_q == ST_IDLE) begin
            if (count_q != '0) begin
                state_d    = ST_BUSY;
                wait_cnt_d = WAIT_LOAD;
            end
        end else if (wait_cnt_q != '0) begin
            wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end else begin
            if (!q_rw_q[head_q]) begin
                ready_d    = 1'b1;
                data_out_d = mem_q[head_idx];
                id_out_d   = q_id_q[head_q];
            end
            // count_d already includes a same-edge push, so no idle gap is inserted.
            if (count_d != '0) begin
                wait_cnt_d = WAIT_LOAD;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            data_out_q <= '0;
            id_out_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            ready_q    <= ready_d;
            data_out_q <= data_out_d;
            id_out_q   <= id_out_d;
        end
    end

    // Payload and backing store carry no reset; memory contents survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_idx_q[tail_q]  <= in_idx;
            q_data_q[tail_q] <= data_in;
            q_rw_q[tail_q]   <= rw_in;
            q_id_q[tail_q]   <= id_in;
        end
        if (!reset && pop && q_rw_q[head_q]) begin
            mem_q[head_idx] <= q_data_q[head_q];
        end
    end

    assign data_out  = data_out_q;
    assign id_out    = id_out_q;
    assign ready_out = ready_q;
    assign stall_out = full;
    assign count_out = count_q;

endmodule
